// File: rtl/jtopl_pkg.sv
// Shared definitions for the OPL phase generator: MULT factor tables, table
// selection encodings and the factor lookup function.
package jtopl_pkg;

  localparam int MULT_OPL    = 0;
  localparam int MULT_LINEAR = 1;

  // Factors are in half-units; the multiplier output is shifted right by one.
  typedef logic [4:0] factor_t;

  localparam factor_t FACTOR_OPL [16] = '{
    5'd1,  5'd2,  5'd4,  5'd6,  5'd8,  5'd10, 5'd12, 5'd14,
    5'd16, 5'd18, 5'd20, 5'd20, 5'd24, 5'd24, 5'd30, 5'd30
  };

  localparam factor_t FACTOR_LINEAR [16] = '{
    5'd1,  5'd2,  5'd4,  5'd6,  5'd8,  5'd10, 5'd12, 5'd14,
    5'd16, 5'd18, 5'd20, 5'd22, 5'd24, 5'd26, 5'd28, 5'd30
  };

  function automatic factor_t pg_factor(input int mode, input logic [3:0] mul);
    return (mode == MULT_LINEAR) ? FACTOR_LINEAR[mul] : FACTOR_OPL[mul];
  endfunction

endpackage

// File: rtl/jtopl_pg_mul.sv
// Combinational MULT stage: scales the pure phase increment by the selected
// half-unit factor and drops the half bit, truncating to the accumulator width.
module jtopl_pg_mul
  import jtopl_pkg::*;
#(
  parameter int PIW       = 18,
  parameter int PHW       = 19,
  parameter int MULT_MODE = MULT_OPL
) (
  input  logic [PIW-1:0] phinc_pure,
  input  logic [3:0]     mul,
  output logic [PHW-1:0] inc
);

  // Wide enough for the full PIW+5 product and for the PHW-bit result after the shift.
  localparam int PW = (PIW + 5 > PHW + 1) ? PIW + 5 : PHW + 1;

  logic [PW-1:0] product;

  always_comb begin
    product = PW'(phinc_pure) * PW'(pg_factor(MULT_MODE, mul));
    inc     = PHW'(product >> 1);
  end

endmodule

// File: rtl/jtopl_pg_acc.sv
// Time-multiplexed phase accumulator: a slot counter walks the operator slots,
// stage 1 registers the scaled increment, stage 2 updates that slot's phase.
module jtopl_pg_acc
  import jtopl_pkg::*;
#(
  parameter int SLOTS     = 18,
  parameter int PHW       = 19,
  parameter int PIW       = 18,
  parameter int OPW       = 10,
  parameter int MULT_MODE = MULT_OPL
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cen,
  input  logic [PIW-1:0]           phinc_pure,
  input  logic [3:0]               mul,
  input  logic                     pg_rst,
  output logic [$clog2(SLOTS)-1:0] slot,
  output logic                     zero,
  output logic [OPW-1:0]           phase_op,
  output logic [$clog2(SLOTS)-1:0] op_slot
);

  localparam int SW = $clog2(SLOTS);

  logic [PHW-1:0] inc_next;
  logic [PHW-1:0] inc1;
  logic           rst1;
  logic [SW-1:0]  s1;
  logic [PHW-1:0] phase_new;
  logic [PHW-1:0] mem [SLOTS];

  jtopl_pg_mul #(
    .PIW       (PIW),
    .PHW       (PHW),
    .MULT_MODE (MULT_MODE)
  ) u_mul (
    .phinc_pure (phinc_pure),
    .mul        (mul),
    .inc        (inc_next)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (cen) begin
      slot <= (slot == SW'(SLOTS - 1)) ? '0 : slot + 1'b1;
    end
  end

  assign zero = (slot == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc1 <= '0;
      rst1 <= 1'b0;
      s1   <= '0;
    end else if (cen) begin
      inc1 <= inc_next;
      rst1 <= pg_rst;
      s1   <= slot;
    end
  end

  // Stage 1 holds a different slot than stage 2 writes, so no bypass is needed.
  always_comb begin
    phase_new = rst1 ? '0 : mem[s1] + inc1;
  end

  // NOTE: the phase array is reset explicitly because a reset mid-round must
  // discard every accumulated phase; this keeps it in flops rather than RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) mem[i] <= '0;
      phase_op <= '0;
      op_slot  <= '0;
    end else if (cen) begin
      mem[s1]  <= phase_new;
      phase_op <= phase_new[PHW-1 -: OPW];
      op_slot  <= s1;
    end
  end

endmodule

// File: tb/tb_jtopl_pg_acc.sv
// Scoreboard bench for jtopl_pg_acc: a per-slot reference model predicts each
// phase result when its inputs are driven; results are compared two cen edges later.
module tb_jtopl_pg_acc;

  localparam int SLOTS = 18;
  localparam int PHW   = 19;
  localparam int PIW   = 18;
  localparam int OPW   = 10;
  localparam int SW    = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cen = 1'b0;
  logic [PIW-1:0] phinc_pure = '0;
  logic [3:0]     mul = '0;
  logic           pg_rst = 1'b0;

  logic [SW-1:0]  slot0, op_slot0, slot1, op_slot1;
  logic           zero0, zero1;
  logic [OPW-1:0] phase_op0, phase_op1;

  always #5 clk = ~clk;

  jtopl_pg_acc #(.SLOTS(SLOTS), .PHW(PHW), .PIW(PIW), .OPW(OPW), .MULT_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .phinc_pure(phinc_pure), .mul(mul),
    .pg_rst(pg_rst), .slot(slot0), .zero(zero0), .phase_op(phase_op0), .op_slot(op_slot0)
  );

  jtopl_pg_acc #(.SLOTS(SLOTS), .PHW(PHW), .PIW(PIW), .OPW(OPW), .MULT_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .phinc_pure(phinc_pure), .mul(mul),
    .pg_rst(pg_rst), .slot(slot1), .zero(zero1), .phase_op(phase_op1), .op_slot(op_slot1)
  );

  typedef struct packed {
    logic [SW-1:0]  slot;
    logic [OPW-1:0] op0;
    logic [OPW-1:0] op1;
  } exp_t;

  exp_t           sb[$];
  exp_t           last_exp;
  int             n_cmp = 0;
  int             n_err = 0;
  logic [PHW-1:0] ph0 [SLOTS];
  logic [PHW-1:0] ph1 [SLOTS];
  logic [OPW-1:0] last_op0 [SLOTS];
  logic [OPW-1:0] last_op1 [SLOTS];
  logic [SW-1:0]  m_slot;
  logic [PIW-1:0] sp [SLOTS];
  logic [3:0]     sm [SLOTS];
  logic           sr [SLOTS];

  function automatic logic [PHW-1:0] ref_inc(input logic [PIW-1:0] p, input logic [3:0] m,
                                             input bit linear);
    logic [4:0]     tab [16];
    logic [4:0]     f;
    logic [PIW+4:0] prod;
    tab = '{5'd1, 5'd2, 5'd4, 5'd6, 5'd8, 5'd10, 5'd12, 5'd14,
            5'd16, 5'd18, 5'd20, 5'd20, 5'd24, 5'd24, 5'd30, 5'd30};
    if (linear) f = (m == 4'd0) ? 5'd1 : {m, 1'b0};
    else        f = tab[m];
    prod = {5'b0, p} * {18'b0, f};
    return prod[PHW:1];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < SLOTS; i++) begin
      ph0[i] = '0;
      ph1[i] = '0;
      last_op0[i] = '0;
      last_op1[i] = '0;
    end
    sb.delete();
    m_slot = '0;
  endtask

  task automatic clear_stim();
    for (int i = 0; i < SLOTS; i++) begin
      sp[i] = '0;
      sm[i] = 4'd1;
      sr[i] = 1'b0;
    end
  endtask

  // One cen cycle: drive inputs for the model's current slot, predict, compare.
  task automatic step(input logic [PIW-1:0] p, input logic [3:0] m, input logic r);
    exp_t e;
    @(negedge clk);
    cen = 1'b1;
    phinc_pure = p;
    mul = m;
    pg_rst = r;
    n_cmp++;
    if ({slot0, zero0, slot1, zero1} !== {m_slot, m_slot == '0, m_slot, m_slot == '0}) begin
      n_err++;
      $display("FAIL slot_counter: slot=%0d/%0d zero=%b/%b, expected slot %0d", slot0, slot1,
               zero0, zero1, m_slot);
    end
    ph0[m_slot] = r ? '0 : ph0[m_slot] + ref_inc(p, m, 1'b0);
    ph1[m_slot] = r ? '0 : ph1[m_slot] + ref_inc(p, m, 1'b1);
    e.slot = m_slot;
    e.op0  = ph0[m_slot][PHW-1 -: OPW];
    e.op1  = ph1[m_slot][PHW-1 -: OPW];
    sb.push_back(e);
    m_slot = (m_slot == SW'(SLOTS - 1)) ? '0 : m_slot + 1'b1;
    @(posedge clk);
    #1;
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      n_cmp++;
      if ({op_slot0, phase_op0} !== {e.slot, e.op0}) begin
        n_err++;
        $display("FAIL phase_mode0: op_slot=%0d phase_op=%h, expected op_slot %0d phase_op %h",
                 op_slot0, phase_op0, e.slot, e.op0);
      end
      n_cmp++;
      if ({op_slot1, phase_op1} !== {e.slot, e.op1}) begin
        n_err++;
        $display("FAIL phase_mode1: op_slot=%0d phase_op=%h, expected op_slot %0d phase_op %h",
                 op_slot1, phase_op1, e.slot, e.op1);
      end
      last_op0[e.slot] = phase_op0;
      last_op1[e.slot] = phase_op1;
      last_exp = e;
    end
  endtask

  task automatic run_round();
    for (int i = 0; i < SLOTS; i++) step(sp[m_slot], sm[m_slot], sr[m_slot]);
  endtask

  // cen low with junk on the inputs: everything visible must hold.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cen = 1'b0;
      phinc_pure = PIW'($urandom);
      mul = 4'($urandom);
      pg_rst = 1'($urandom);
      @(posedge clk);
      #1;
      n_cmp++;
      if ({slot0, op_slot0, phase_op0, slot1, op_slot1, phase_op1} !==
          {m_slot, last_exp.slot, last_exp.op0, m_slot, last_exp.slot, last_exp.op1}) begin
        n_err++;
        $display("FAIL cen_hold: slot=%0d op_slot=%0d phase_op=%h/%h, expected %0d %0d %h/%h",
                 slot0, op_slot0, phase_op0, phase_op1, m_slot, last_exp.slot,
                 last_exp.op0, last_exp.op1);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cen = 1'($urandom);
      phinc_pure = PIW'($urandom);
      mul = 4'($urandom);
      pg_rst = 1'($urandom);
      @(posedge clk);
      #1;
      n_cmp++;
      if ({slot0, zero0, phase_op0, op_slot0, slot1, zero1, phase_op1, op_slot1} !==
          {5'd0, 1'b1, 10'd0, 5'd0, 5'd0, 1'b1, 10'd0, 5'd0}) begin
        n_err++;
        $display("FAIL reset_state: slot=%0d zero=%b phase_op=%h op_slot=%0d, expected 0 1 0 0",
                 slot0, zero0, phase_op0, op_slot0);
      end
    end
    @(negedge clk);
    cen = 1'b0;
    pg_rst = 1'b0;
    rst_n = 1'b1;
    clear_model();
  endtask

  task automatic test_basic();
    test_reset();
    clear_stim();
    sp[3] = 18'h100;
    repeat (2) run_round();
    n_cmp++;
    if ({last_op0[3], last_op1[3], last_op0[4]} !== {10'd1, 10'd1, 10'd0}) begin
      n_err++;
      $display("FAIL basic_accum: slot3=%h/%h slot4=%h, expected 1/1 0",
               last_op0[3], last_op1[3], last_op0[4]);
    end
  endtask

  task automatic test_truncation();
    test_reset();
    clear_stim();
    for (int i = 0; i < SLOTS; i++) sm[i] = 4'd0;
    sp[7] = 18'd3;
    repeat (511) run_round();
    n_cmp++;
    if (last_op0[7] !== 10'd0) begin
      n_err++;
      $display("FAIL trunc_511: phase_op=%h, expected 0", last_op0[7]);
    end
    run_round();
    n_cmp++;
    if ({last_op0[7], last_op1[7]} !== {10'd1, 10'd1}) begin
      n_err++;
      $display("FAIL trunc_512: phase_op=%h/%h, expected 1/1", last_op0[7], last_op1[7]);
    end
  endtask

  task automatic test_wrap();
    logic [OPW-1:0] want [4];
    want = '{10'h100, 10'h200, 10'h300, 10'h000};
    test_reset();
    clear_stim();
    sp[2] = 18'h20000;
    for (int r = 0; r < 4; r++) begin
      run_round();
      n_cmp++;
      if (last_op0[2] !== want[r]) begin
        n_err++;
        $display("FAIL wrap_round%0d: phase_op=%h, expected %h", r + 1, last_op0[2], want[r]);
      end
    end
  endtask

  task automatic test_key_on();
    test_reset();
    clear_stim();
    sp[5] = 18'h400;
    sp[6] = 18'h400;
    repeat (2) run_round();
    sr[5] = 1'b1;
    run_round();
    n_cmp++;
    if ({last_op0[5], last_op0[6]} !== {10'd0, 10'd6}) begin
      n_err++;
      $display("FAIL key_on_reset: slot5=%h slot6=%h, expected 0 6", last_op0[5], last_op0[6]);
    end
    sr[5] = 1'b0;
    run_round();
    n_cmp++;
    if ({last_op0[5], last_op0[6]} !== {10'd2, 10'd8}) begin
      n_err++;
      $display("FAIL key_on_resume: slot5=%h slot6=%h, expected 2 8", last_op0[5], last_op0[6]);
    end
  endtask

  task automatic test_mult_mode();
    test_reset();
    clear_stim();
    sp[2] = 18'h200;
    sm[2] = 4'd11;
    run_round();
    n_cmp++;
    if ({last_op0[2], last_op1[2]} !== {10'd10, 10'd11}) begin
      n_err++;
      $display("FAIL mult_mode_r1: mode0=%0d mode1=%0d, expected 10 11", last_op0[2], last_op1[2]);
    end
    run_round();
    n_cmp++;
    if ({last_op0[2], last_op1[2]} !== {10'd20, 10'd22}) begin
      n_err++;
      $display("FAIL mult_mode_r2: mode0=%0d mode1=%0d, expected 20 22", last_op0[2], last_op1[2]);
    end
  endtask

  task automatic test_cen_gating();
    test_reset();
    for (int i = 0; i < SLOTS; i++) begin
      sp[i] = PIW'($urandom);
      sm[i] = 4'($urandom);
      sr[i] = 1'b0;
    end
    run_round();
    for (int i = 0; i < 9; i++) step(sp[m_slot], sm[m_slot], sr[m_slot]);
    idle(7);
    for (int i = 0; i < 9; i++) step(sp[m_slot], sm[m_slot], sr[m_slot]);
    run_round();
  endtask

  task automatic test_back_to_back();
    test_reset();
    for (int i = 0; i < 3 * SLOTS + 5; i++)
      step(PIW'($urandom), 4'($urandom), ($urandom_range(0, 7) == 0));
    test_reset();
    for (int i = 0; i < 2 * SLOTS; i++)
      step(PIW'($urandom), 4'($urandom), ($urandom_range(0, 7) == 0));
  endtask

  initial begin
    clear_model();
    clear_stim();
    last_exp = '0;
    test_reset();
    test_basic();
    test_truncation();
    test_wrap();
    test_key_on();
    test_mult_mode();
    test_cen_gating();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
